// File: rtl/deserializer_rx.sv
// deserializer_rx: MSB-first serial-to-parallel receiver; frames end on WIDTH bits or valid drop.
// Optional DESER_SHORT_ERR_EN adds short_err_o, pulsed when a frame under 3 bits is discarded.
module deserializer_rx #(
  parameter int WIDTH    = 8,
  parameter int MOD_BITS = 4
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                ser_data_i,
  input  logic                ser_data_val_i,
  output logic [WIDTH-1:0]    deser_data_o,
  output logic [MOD_BITS-1:0] deser_mod_o,
  output logic                deser_data_val_o,
`ifdef DESER_SHORT_ERR_EN
  output logic                short_err_o,
`endif
  output logic                busy_o
);
  typedef enum logic {IDLE, RECV} state_t;
  localparam logic [MOD_BITS-1:0] FULL = MOD_BITS'(WIDTH);
  localparam logic [MOD_BITS-1:0] MIN  = MOD_BITS'(3);
  state_t              state, state_n;
  logic [WIDTH-1:0]    sr, sr_n, ins, pos, emit_data;
  logic [MOD_BITS-1:0] cnt, cnt_n, cnt_inc, emit_mod;
  logic                emit, short_n;
  // sr and cnt are zero in IDLE, so the first bit lands at the MSB through the same path
  assign pos     = {1'b1, {(WIDTH-1){1'b0}}} >> cnt;
  assign ins     = sr | (ser_data_i ? pos : '0);
  assign cnt_inc = cnt + MOD_BITS'(1);
  assign busy_o  = state == RECV;
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    emit      = 1'b0;
    short_n   = 1'b0;
    emit_data = sr;
    emit_mod  = cnt;
    if (state == IDLE) begin
      if (ser_data_val_i) begin
        sr_n    = ins;
        cnt_n   = MOD_BITS'(1);
        state_n = RECV;
      end
    end else if (ser_data_val_i && cnt_inc != FULL) begin
      sr_n  = ins;
      cnt_n = cnt_inc;
    end else begin
      emit      = ser_data_val_i || cnt >= MIN;
      short_n   = !ser_data_val_i && cnt < MIN;
      emit_data = ser_data_val_i ? ins : sr;
      emit_mod  = ser_data_val_i ? FULL : cnt;
      sr_n      = '0;
      cnt_n     = '0;
      state_n   = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state            <= IDLE;
      sr               <= '0;
      cnt              <= '0;
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      state            <= state_n;
      sr               <= sr_n;
      cnt              <= cnt_n;
      deser_data_o     <= emit ? emit_data : deser_data_o;
      deser_mod_o      <= emit ? emit_mod : deser_mod_o;
      deser_data_val_o <= emit;
    end
  end
`ifdef DESER_SHORT_ERR_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) short_err_o <= 1'b0;
    else short_err_o <= short_n;
  end
`else
  logic unused_short;
  assign unused_short = short_n;
`endif
endmodule
